// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one completing functional unit per cycle and registers its payload.
// Define CDB_ARB_RR_EN for round-robin arbitration; otherwise the lowest valid index wins.
module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_W     = 6,
    parameter int ROB_IDX_W = 5
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           squash,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]       req_tag,
    input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx,
    input  logic [NUM_REQ*32-1:0]          req_result,
    input  logic [NUM_REQ*32-1:0]          req_rs2_value,
    input  logic [NUM_REQ-1:0]             req_take_branch,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [TAG_W-1:0]               cdb,
    output logic                           cdb_en,
    output logic [ROB_IDX_W-1:0]           complete_idx,
    output logic [31:0]                    result,
    output logic [31:0]                    rs2_value,
    output logic                           take_branch
);

    logic                 w_en;
    logic [NUM_REQ-1:0]   w_grant;
    logic                 w_found;
    logic [TAG_W-1:0]     w_tag;
    logic [ROB_IDX_W-1:0] w_rob_idx;
    logic [31:0]          w_result;
    logic [31:0]          w_rs2_value;
    logic                 w_take_branch;

    logic [TAG_W-1:0]     r_cdb;
    logic                 r_cdb_en;
    logic [ROB_IDX_W-1:0] r_complete_idx;
    logic [31:0]          r_result;
    logic [31:0]          r_rs2_value;
    logic                 r_take_branch;

    assign w_en = !reset && !squash;

`ifdef CDB_ARB_RR_EN
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     w_ptr_nxt;
    logic [PTR_W-1:0]     w_gnt_idx;
    logic [PTR_W:0]       w_sum;
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;

    // Rotate so that bit 0 of w_rot is the requester at the pointer.
    assign w_dbl = {req_valid, req_valid};
    assign w_rot = NUM_REQ'(w_dbl >> r_ptr);

    always_comb begin
        w_found = 1'b0;
        w_sum   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (PTR_W+1)'(j);
            end
        end
        if (w_sum >= (PTR_W+1)'(NUM_REQ))
            w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
        w_gnt_idx = w_sum[PTR_W-1:0];

        w_grant = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_grant[i] = w_en && w_found && (w_gnt_idx == PTR_W'(i));

        w_ptr_nxt = r_ptr;
        if (w_en && w_found)
            w_ptr_nxt = (w_gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + PTR_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) r_ptr <= '0;
        else       r_ptr <= w_ptr_nxt;
    end
`else
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i]) begin
                w_found    = 1'b1;
                w_grant[i] = w_en;
            end
        end
    end
`endif

    always_comb begin
        w_tag         = '0;
        w_rob_idx     = '0;
        w_result      = '0;
        w_rs2_value   = '0;
        w_take_branch = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_tag         = req_tag[i*TAG_W +: TAG_W];
                w_rob_idx     = req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                w_result      = req_result[i*32 +: 32];
                w_rs2_value   = req_rs2_value[i*32 +: 32];
                w_take_branch = req_take_branch[i];
            end
        end
    end

    // Payload registers only move on a transfer; otherwise they hold for late readers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cdb          <= '0;
            r_cdb_en       <= 1'b0;
            r_complete_idx <= '0;
            r_result       <= '0;
            r_rs2_value    <= '0;
            r_take_branch  <= 1'b0;
        end else begin
            r_cdb_en <= |w_grant;
            if (|w_grant) begin
                r_cdb          <= w_tag;
                r_complete_idx <= w_rob_idx;
                r_result       <= w_result;
                r_rs2_value    <= w_rs2_value;
                r_take_branch  <= w_take_branch;
            end
        end
    end

    assign req_ready    = w_grant;
    assign cdb          = r_cdb;
    assign cdb_en       = r_cdb_en;
    assign complete_idx = r_complete_idx;
    assign result       = r_result;
    assign rs2_value    = r_rs2_value;
    assign take_branch  = r_take_branch;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by random traffic,
// compared against an arithmetic reference model of the arbitration rules.
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int TW = 6;
    localparam int RW = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic              squash;
    logic [N-1:0]      req_valid;
    logic [N*TW-1:0]   req_tag;
    logic [N*RW-1:0]   req_rob_idx;
    logic [N*32-1:0]   req_result;
    logic [N*32-1:0]   req_rs2_value;
    logic [N-1:0]      req_take_branch;
    logic [N-1:0]      req_ready;
    logic [TW-1:0]     cdb;
    logic              cdb_en;
    logic [RW-1:0]     complete_idx;
    logic [31:0]       result;
    logic [31:0]       rs2_value;
    logic              take_branch;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state
    int          m_ptr = 0;
    logic [TW-1:0] m_cdb = '0;
    logic        m_en = 1'b0;
    logic [RW-1:0] m_idx = '0;
    logic [31:0] m_res = '0;
    logic [31:0] m_rs2 = '0;
    logic        m_tb = 1'b0;
    logic [N-1:0] g_obs;

    cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .ROB_IDX_W(RW)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .req_valid(req_valid), .req_tag(req_tag), .req_rob_idx(req_rob_idx),
        .req_result(req_result), .req_rs2_value(req_rs2_value),
        .req_take_branch(req_take_branch), .req_ready(req_ready),
        .cdb(cdb), .cdb_en(cdb_en), .complete_idx(complete_idx),
        .result(result), .rs2_value(rs2_value), .take_branch(take_branch)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner();
        if (reset || squash) return -1;
        for (int k = 0; k < N; k++) begin
`ifdef CDB_ARB_RR_EN
            int idx = (m_ptr + k) % N;
`else
            int idx = k;
`endif
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [TW-1:0] t, input logic [RW-1:0] r,
                           input logic [31:0] res, input logic [31:0] rs2, input logic tb);
        req_tag[i*TW +: TW]      = t;
        req_rob_idx[i*RW +: RW]  = r;
        req_result[i*32 +: 32]   = res;
        req_rs2_value[i*32 +: 32] = rs2;
        req_take_branch[i]       = tb;
    endtask

    // One clock: check the combinational grant, advance model at the edge, check registered outputs.
    task automatic cycle(input string tag);
        int w;
        logic [N-1:0] exp_g;
        #1;
        w = model_winner();
        exp_g = (w < 0) ? '0 : N'(1) << w;
        g_obs = req_ready;
        chk({tag, ".ready"}, 64'(req_ready), 64'(exp_g));
        @(posedge clock);
        if (reset) begin
            m_ptr = 0; m_cdb = '0; m_en = 1'b0; m_idx = '0; m_res = '0; m_rs2 = '0; m_tb = 1'b0;
        end else if (w >= 0) begin
            m_en  = 1'b1;
            m_cdb = req_tag[w*TW +: TW];
            m_idx = req_rob_idx[w*RW +: RW];
            m_res = req_result[w*32 +: 32];
            m_rs2 = req_rs2_value[w*32 +: 32];
            m_tb  = req_take_branch[w];
`ifdef CDB_ARB_RR_EN
            m_ptr = (w + 1) % N;
`endif
        end else begin
            m_en = 1'b0;
        end
        #1;
        chk({tag, ".cdb_en"}, 64'(cdb_en), 64'(m_en));
        chk({tag, ".cdb"}, 64'(cdb), 64'(m_cdb));
        chk({tag, ".complete_idx"}, 64'(complete_idx), 64'(m_idx));
        chk({tag, ".result"}, 64'(result), 64'(m_res));
        chk({tag, ".rs2_value"}, 64'(rs2_value), 64'(m_rs2));
        chk({tag, ".take_branch"}, 64'(take_branch), 64'(m_tb));
    endtask

    initial begin
        logic [N-1:0] exp_seq [5];
        reset = 1'b1; squash = 1'b0; req_valid = 4'b1111;
        req_tag = '0; req_rob_idx = '0; req_result = '0; req_rs2_value = '0; req_take_branch = '0;
        @(posedge clock); #1;

        // reset held with all requesters valid
        cycle("reset0");
        chk("reset0.ready_zero", 64'(g_obs), 64'(0));
        cycle("reset1");
        reset = 1'b0; req_valid = '0;
        cycle("post_reset");
        chk("post_reset.cdb_en", 64'(cdb_en), 64'(0));

        // single request
        set_req(1, 6'd17, 5'd3, 32'hDEADBEEF, 32'h1234_5678, 1'b1);
        req_valid = 4'b0010;
        cycle("single");
        chk("single.grant", 64'(g_obs), 64'(4'b0010));
        chk("single.tag17", 64'(cdb), 64'(17));
        chk("single.idx3", 64'(complete_idx), 64'(3));
        chk("single.res", 64'(result), 64'(32'hDEADBEEF));
        chk("single.en", 64'(cdb_en), 64'(1));

        // contention from the reset pointer
        reset = 1'b1; req_valid = '0;
        cycle("rst_c");
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, TW'(40 + i), RW'(10 + i), 32'(i * 1000), 32'(i * 7), i[0]);
        req_valid = 4'b1111;
`ifdef CDB_ARB_RR_EN
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        for (int k = 0; k < 5; k++) begin
            cycle("contend");
            chk("contend.seq", 64'(g_obs), 64'(exp_seq[k]));
        end

        // wrap: grant 2, then 1001
        reset = 1'b1; req_valid = '0;
        cycle("rst_w");
        reset = 1'b0; req_valid = 4'b0100;
        cycle("wrap_g2");
        req_valid = 4'b1001;
        cycle("wrap_a");
`ifdef CDB_ARB_RR_EN
        chk("wrap.first", 64'(g_obs), 64'(4'b1000));
`else
        chk("wrap.first", 64'(g_obs), 64'(4'b0001));
`endif
        cycle("wrap_b");
        chk("wrap.second", 64'(g_obs), 64'(4'b0001));

        // squash then release
        req_valid = 4'b0100; squash = 1'b1;
        cycle("squash");
        chk("squash.ready", 64'(g_obs), 64'(0));
        chk("squash.en", 64'(cdb_en), 64'(0));
        squash = 1'b0;
        cycle("unsquash");
        chk("unsquash.grant", 64'(g_obs), 64'(4'b0100));

        // idle hold
        req_valid = '0;
        for (int k = 0; k < 3; k++) cycle("idle");

        // random traffic with occasional squash and reset
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++)
                set_req(i, TW'($urandom), RW'($urandom), $urandom, $urandom, 1'($urandom));
            req_valid = N'($urandom);
            squash    = ($urandom_range(0, 7) == 0);
            reset     = ($urandom_range(0, 31) == 0);
            cycle("rand");
        end
        reset = 1'b0; squash = 1'b0; req_valid = '0;
        cycle("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, 4, number of functional-unit requesters (any value >= 2, not only powers of two).
REQ-002 SHALL have parameter TAG_W, 6, physical-register tag width.
REQ-003 SHALL have parameter ROB_IDX_W, 5, ROB index width.
REQ-004 SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port squash  input  1  branch-mispredict flush.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-FU completion request.
REQ-008 SHALL have port req_tag  input  NUM_REQ*TAG_W  destination tags, requester i in bits [i*TAG_W +: TAG_W].
REQ-009 SHALL have port req_rob_idx  input  NUM_REQ*ROB_IDX_W  ROB indices, packed the same way.
REQ-010 SHALL have port req_result  input  NUM_REQ*32  results.
REQ-011 SHALL have port req_rs2_value  input  NUM_REQ*32  store data.
REQ-012 SHALL have port req_take_branch  input  NUM_REQ  branch-taken flags.
REQ-013 SHALL have port req_ready  output  NUM_REQ  one-hot grant.
REQ-014 SHALL have port cdb  output  TAG_W  broadcast tag.
REQ-015 SHALL have port cdb_en  output  1  broadcast valid; also ROB complete enable.
REQ-016 SHALL have ports complete_idx  output  ROB_IDX_W; result  output  32; rs2_value  output  32; take_branch  output  1.

Function
REQ-017 SHALL drive req_ready combinationally from req_valid, the priority pointer, squash and reset.
REQ-018 SHALL assert at most one req_ready bit, and only for a requester whose req_valid is high.
REQ-019 SHALL grant some requester whenever any req_valid is high and squash and reset are both low (work-conserving).
REQ-020 SHALL define a transfer as req_valid[i] and req_ready[i] high at a rising edge.
REQ-021 Requesters SHALL hold valid and payload stable until granted; the arbiter SHALL NOT store ungranted payloads.
REQ-022 SHALL register the granted payload (tag, rob_idx, result, rs2_value, take_branch) and set cdb_en=1 on the edge of the transfer, giving a latency of 1 cycle.
REQ-023 SHALL load cdb_en=0 on an edge with no transfer; payload outputs then hold their previous values.
REQ-024 SHALL keep a priority pointer of $clog2(NUM_REQ) bits; the search starts at the pointer index and proceeds upward with wrap-around.
REQ-025 After a grant to requester i, the pointer SHALL become i+1, wrapping from NUM_REQ-1 to 0.
REQ-026 With no grant, the pointer SHALL be unchanged.
REQ-027 While squash=1, req_ready SHALL be all-zero, cdb_en SHALL load 0 at the edge, and the pointer SHALL be unchanged.
REQ-028 squash SHALL NOT clear the current-cycle output register contents before the edge.

Reset
REQ-029 With reset high at an edge: cdb, complete_idx, result, rs2_value, take_branch, cdb_en and the pointer SHALL all load 0.
REQ-030 While reset is high, req_ready SHALL be all-zero.
REQ-031 reset SHALL take priority over squash and over any pending grant; a reset mid-stream SHALL drop in-flight grants.

Configuration
REQ-032 With macro CDB_ARB_RR_EN defined, arbitration SHALL be round-robin per REQ-024..026.
REQ-033 With CDB_ARB_RR_EN undefined, arbitration SHALL be fixed priority: the lowest valid index wins, the pointer logic is absent, and everything else is identical.

Verification (NUM_REQ=4, TAG_W=6, ROB_IDX_W=5)
REQ-034 Reset: reset=1 for 2 cycles with req_valid=4'b1111 -> req_ready=0; after reset drops, cdb_en=0 and all outputs are 0.
REQ-035 Single request: req_valid=4'b0010, tag=17, rob_idx=3, result=32'hDEADBEEF -> req_ready=4'b0010 same cycle; next cycle cdb=17, cdb_en=1, complete_idx=3, result=32'hDEADBEEF.
REQ-036 Contention: req_valid=4'b1111 held for 5 cycles from the reset pointer -> grants 0001, 0010, 0100, 1000, 0001 with the macro defined; 0001 every cycle without it.
REQ-037 Wrap: grant to requester 2, then req_valid=4'b1001 -> grant 1000, then 0001 (pointer wraps 3->0).
REQ-038 Squash: req_valid=4'b0100, squash=1 -> req_ready=0 and cdb_en=0 next cycle; the following cycle with squash=0 grants 0100 using the unchanged pointer.
REQ-039 Idle: req_valid=0 for 3 cycles -> cdb_en=0 each cycle, pointer unchanged, payload outputs hold.
